// File: rtl/bitwise_serial_logic_pkg.sv
// Shared encodings for the bit-serial logic unit and the combinational ALU decoder.
package bitwise_serial_logic_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/bitwise_serial_logic_if.sv
// Controller-side bus of the bit-serial logic unit.
// Handshake: start is a request taken only while idle (busy=0, done=0); op/X/Y are
// captured with it. done is a one-cycle pulse during which Z holds the new result.
interface bitwise_serial_logic_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic         busy;
    logic         done;
    logic [N-1:0] Z;

    modport master (
        output start, op, X, Y,
        input  busy, done, Z
    );

    modport slave (
        input  start, op, X, Y,
        output busy, done, Z
    );
endinterface

// File: rtl/bitwise_serial_logic_slice.sv
// Combinational W-bit logic slice; also the building block for the wide ALU unit.
module bitwise_logic_slice
    import bitwise_serial_logic_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/bitwise_serial_logic.sv
// Bit-serial AND/OR/XOR/NOR over N-bit operands, BITS_PER_CYCLE bits per clock, LSB first.
module bitwise_serial_logic
    import bitwise_serial_logic_pkg::*;
#(
    parameter int N              = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bitwise_serial_logic_if.slave bus,
    output state_t                fsm_state
);

    localparam int STEPS = N / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (BITS_PER_CYCLE < 1 || (N % BITS_PER_CYCLE) != 0) begin : g_bad_width
            $error("bitwise_serial_logic: N must be a positive multiple of BITS_PER_CYCLE");
        end
    endgenerate

    state_t                    state;
    state_t                    state_n;
    logic                      load;
    logic                      step;
    logic [N-1:0]              x_sr;
    logic [N-1:0]              y_sr;
    logic [N-1:0]              acc;
    logic [N-1:0]              acc_n;
    logic [N-1:0]              z_q;
    logic [1:0]                op_q;
    logic [CW-1:0]             cnt;
    logic [BITS_PER_CYCLE-1:0] slice_y;
    logic [N+BITS_PER_CYCLE-1:0] acc_cat;

    bitwise_logic_slice #(.W(BITS_PER_CYCLE)) u_slice (
        .a  (x_sr[BITS_PER_CYCLE-1:0]),
        .b  (y_sr[BITS_PER_CYCLE-1:0]),
        .op (op_q),
        .y  (slice_y)
    );

    // New slice enters at the MSB end; after STEPS shifts the first slice sits at bit 0.
    assign acc_cat = {slice_y, acc};
    assign acc_n   = acc_cat[N+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == '0) state_n = ST_FINISH;
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sr <= '0;
            y_sr <= '0;
            acc  <= '0;
            z_q  <= '0;
            op_q <= OP_AND;
            cnt  <= '0;
        end else if (load) begin
            x_sr <= bus.X;
            y_sr <= bus.Y;
            op_q <= bus.op;
            acc  <= '0;
            cnt  <= CW'(STEPS - 1);
        end else if (step) begin
            x_sr <= x_sr >> BITS_PER_CYCLE;
            y_sr <= y_sr >> BITS_PER_CYCLE;
            acc  <= acc_n;
            if (cnt == '0) begin
                // Z changes on the edge into FINISH so it is valid alongside done.
                z_q <= acc_n;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_FINISH);
    assign bus.Z     = z_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_bitwise_serial_logic.sv
// Bench for bitwise_serial_logic: three instances (1, 4 and 8 bits per cycle) share one stimulus.
module tb_bitwise_serial_logic;
    import bitwise_serial_logic_pkg::*;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] x;
    logic [N-1:0] y;

    logic         busy_v [3];
    logic         done_v [3];
    logic [N-1:0] z_v    [3];
    state_t       st_v   [3];

    int lat [3] = '{33, 9, 5};
    int bpc [3] = '{1, 4, 8};

    int errors = 0;
    int checks = 0;

    bitwise_serial_logic_if #(.N(N)) bus0 ();
    bitwise_serial_logic_if #(.N(N)) bus4 ();
    bitwise_serial_logic_if #(.N(N)) bus8 ();

    assign bus0.start = start; assign bus0.op = op; assign bus0.X = x; assign bus0.Y = y;
    assign bus4.start = start; assign bus4.op = op; assign bus4.X = x; assign bus4.Y = y;
    assign bus8.start = start; assign bus8.op = op; assign bus8.X = x; assign bus8.Y = y;

    assign busy_v[0] = bus0.busy; assign done_v[0] = bus0.done; assign z_v[0] = bus0.Z;
    assign busy_v[1] = bus4.busy; assign done_v[1] = bus4.done; assign z_v[1] = bus4.Z;
    assign busy_v[2] = bus8.busy; assign done_v[2] = bus8.done; assign z_v[2] = bus8.Z;

    bitwise_serial_logic #(.N(N), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .fsm_state(st_v[0]));
    bitwise_serial_logic #(.N(N), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .fsm_state(st_v[1]));
    bitwise_serial_logic #(.N(N), .BITS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8), .fsm_state(st_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] ref_logic(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [1:0] o);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            start = 1'($urandom_range(0, 1));
            op    = 2'($urandom_range(0, 3));
            x     = $urandom;
            y     = $urandom;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({busy_v[i], done_v[i], z_v[i]} !== {2'b00, 32'h0}) begin
                    errors++;
                    $display("FAIL reset_hold bpc=%0d busy=%b done=%b z=%h expected 0/0/0", bpc[i],
                             busy_v[i], done_v[i], z_v[i]);
                end
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({busy_v[i], done_v[i], z_v[i]} !== {2'b00, 32'h0}) begin
                    errors++;
                    $display("FAIL reset_idle bpc=%0d busy=%b done=%b z=%h expected 0/0/0", bpc[i],
                             busy_v[i], done_v[i], z_v[i]);
                end
            end
        end
    endtask

    // One start pulse; inputs are scrambled right after the start cycle.
    task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] ya, input logic [1:0] o,
                          input logic [N-1:0] exp_z, input string name);
        int           dn [3];
        int           at [3];
        int           bc [3];
        logic [N-1:0] zc [3];
        for (int i = 0; i < 3; i++) begin
            dn[i] = 0; at[i] = -1; bc[i] = 0; zc[i] = '0;
        end
        @(negedge clk);
        x = xa; y = ya; op = o; start = 1'b1;
        for (int j = 1; j <= 36; j++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i]) bc[i]++;
                if (done_v[i]) begin
                    if (dn[i] == 0) begin
                        at[i] = j;
                        zc[i] = z_v[i];
                    end
                    dn[i]++;
                end
            end
            if (j == 1) begin
                start = 1'b0;
                x = $urandom; y = $urandom; op = 2'($urandom_range(0, 3));
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks += 5;
            if (dn[i] != 1) begin
                errors++;
                $display("FAIL %s done_count bpc=%0d got %0d expected 1", name, bpc[i], dn[i]);
            end
            if (at[i] != lat[i]) begin
                errors++;
                $display("FAIL %s latency bpc=%0d got %0d expected %0d", name, bpc[i], at[i], lat[i]);
            end
            if (bc[i] != lat[i] - 1) begin
                errors++;
                $display("FAIL %s busy_cycles bpc=%0d got %0d expected %0d", name, bpc[i], bc[i],
                         lat[i] - 1);
            end
            if (zc[i] !== exp_z) begin
                errors++;
                $display("FAIL %s z_at_done bpc=%0d got %h expected %h", name, bpc[i], zc[i], exp_z);
            end
            if (z_v[i] !== exp_z) begin
                errors++;
                $display("FAIL %s z_held bpc=%0d got %h expected %h", name, bpc[i], z_v[i], exp_z);
            end
        end
    endtask

    task automatic test_and();
        run_op(32'hF0F0_A5A5, 32'h0FF0_FFFF, OP_AND, 32'h00F0_A5A5, "and");
    endtask

    task automatic test_all_ops();
        run_op(32'hDEAD_BEEF, 32'h1234_5678, OP_OR,  32'hDEBD_FEFF, "or");
        run_op(32'hDEAD_BEEF, 32'h1234_5678, OP_XOR, 32'hCC99_E897, "xor");
        run_op(32'hDEAD_BEEF, 32'h1234_5678, OP_NOR, 32'h2142_0100, "nor");
        run_op(32'hDEAD_BEEF, 32'h1234_5678, OP_AND, 32'h1224_1668, "and2");
    endtask

    // Second start at cycle 10: ignored by the 1-bit unit, accepted by the faster idle ones.
    task automatic test_start_during_busy();
        int           dn [3];
        int           bc0;
        logic [N-1:0] exp1;
        logic [N-1:0] exp2;
        exp1 = ref_logic(32'h1357_9BDF, 32'hFFFF_0000, OP_AND);
        exp2 = ref_logic(32'hAAAA_5555, 32'h0F0F_0F0F, OP_XOR);
        for (int i = 0; i < 3; i++) dn[i] = 0;
        bc0 = 0;
        @(negedge clk);
        x = 32'h1357_9BDF; y = 32'hFFFF_0000; op = OP_AND; start = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (done_v[i]) dn[i]++;
            if (busy_v[0]) bc0++;
            if (j == 1) start = 1'b0;
            if (j == 10) begin
                x = 32'hAAAA_5555; y = 32'h0F0F_0F0F; op = OP_XOR; start = 1'b1;
            end
            if (j == 11) start = 1'b0;
        end
        checks += 3;
        if (dn[0] != 1) begin
            errors++;
            $display("FAIL busy_start done_count bpc=1 got %0d expected 1", dn[0]);
        end
        if (bc0 != 32) begin
            errors++;
            $display("FAIL busy_start busy_cycles bpc=1 got %0d expected 32", bc0);
        end
        if (z_v[0] !== exp1) begin
            errors++;
            $display("FAIL busy_start z bpc=1 got %h expected %h", z_v[0], exp1);
        end
        for (int i = 1; i < 3; i++) begin
            checks += 2;
            if (dn[i] != 2) begin
                errors++;
                $display("FAIL idle_start done_count bpc=%0d got %0d expected 2", bpc[i], dn[i]);
            end
            if (z_v[i] !== exp2) begin
                errors++;
                $display("FAIL idle_start z bpc=%0d got %h expected %h", bpc[i], z_v[i], exp2);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int dn;
        dn = 0;
        @(negedge clk);
        x = $urandom; y = $urandom; op = 2'($urandom_range(0, 3)); start = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
        end
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset precondition busy bpc=1 got %b expected 1", busy_v[0]);
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy_v[i], done_v[i], z_v[i]} !== {2'b00, 32'h0}) begin
                errors++;
                $display("FAIL mid_reset outputs bpc=%0d busy=%b done=%b z=%h expected 0/0/0", bpc[i],
                         busy_v[i], done_v[i], z_v[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (done_v[i] || busy_v[i] || z_v[i] != 0) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL mid_reset quiet_after got %0d active samples expected 0", dn);
        end
    endtask

    task automatic test_back_to_back();
        int           first  [3];
        int           second [3];
        int           dn     [3];
        logic [N-1:0] exp_q [$];
        logic [N-1:0] exp_z;
        for (int i = 0; i < 3; i++) begin
            first[i] = -1; second[i] = -1; dn[i] = 0;
        end
        @(negedge clk);
        x = $urandom; y = $urandom; op = 2'($urandom_range(0, 3)); start = 1'b1;
        exp_q.push_back(ref_logic(x, y, op));
        for (int j = 1; j <= 80; j++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) begin
                    if (dn[i] == 0) first[i] = j;
                    else if (dn[i] == 1) second[i] = j;
                    dn[i]++;
                    checks++;
                    if (z_v[i] !== exp_q[0]) begin
                        errors++;
                        $display("FAIL b2b z bpc=%0d got %h expected %h", bpc[i], z_v[i], exp_q[0]);
                    end
                end
            end
        end
        start = 1'b0;
        exp_z = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (first[i] != lat[i]) begin
                errors++;
                $display("FAIL b2b first_done bpc=%0d got %0d expected %0d", bpc[i], first[i], lat[i]);
            end
            if (second[i] != 2 * lat[i] + 1) begin
                errors++;
                $display("FAIL b2b second_done bpc=%0d got %0d expected %0d", bpc[i], second[i],
                         2 * lat[i] + 1);
            end
        end
        repeat (40) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (z_v[i] !== exp_z) begin
                errors++;
                $display("FAIL b2b z_final bpc=%0d got %h expected %h", bpc[i], z_v[i], exp_z);
            end
        end
    endtask

    task automatic test_random_sweep();
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [1:0]   ro;
        for (int t = 0; t < 1000; t++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 2'($urandom_range(0, 3));
            run_op(ra, rb, ro, ref_logic(ra, rb, ro), "sweep");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        x     = '0;
        y     = '0;
        test_reset();
        test_and();
        test_all_ops();
        test_start_during_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
